// File: rtl/seq_game_ctrl.sv
// rtl/seq_game_ctrl.sv - Simon-style sequence game controller driven by a 30-bit pattern ROM
module seq_game_ctrl #(
   parameter int STEP_TICKS    = 25_000_000,
   parameter int GAP_TICKS     = 12_500_000,
   parameter int TIMEOUT_TICKS = 250_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  sel,
   output logic [3:0]  rom_dir,
   input  logic [29:0] rom_dato,
   input  logic        btn_valid,
   input  logic [2:0]  btn_code,
   output logic [2:0]  show_code,
   output logic [3:0]  level,
   output logic        busy,
   output logic        win,
   output logic        lose
);

   // One shared tick counter serves SHOW, GAP and the INPUT timeout, so it is
   // sized for the largest of the three durations.
   localparam int MAX_SG = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
   localparam int MAX_T  = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
   localparam int TICK_W = $clog2(MAX_T + 1);

   localparam logic [TICK_W-1:0] STEP_LAST = TICK_W'(STEP_TICKS - 1);
   localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
   localparam logic [TICK_W-1:0] TO_LAST   = TICK_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
   localparam logic              TO_EN     = (TIMEOUT_TICKS != 0);
   localparam logic [3:0]        MAX_LEVEL = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          rom_dir_q, rom_dir_d;
   logic [29:0]         pattern_q, pattern_d;
   logic [3:0]          level_q, level_d;
   logic [3:0]          idx_q, idx_d;
   logic                replay_q, replay_d;
   logic [2:0]          show_q, show_d;
   logic                busy_q, busy_d;
   logic                win_q, win_d;
   logic                lose_q, lose_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic                last_step;

   // Step k of the pattern word, first step in the top three bits.
   function automatic logic [2:0] step_at(input logic [29:0] pat, input logic [3:0] idx);
      logic [5:0]  amt;
      logic [29:0] shifted;
      amt     = {2'b00, idx} * 6'd3;
      shifted = pat << amt;
      return shifted[29:27];
   endfunction

   // Next-state and next-output logic; tick counter restarts on every state entry.
   always_comb begin
      state_d   = state_q;
      rom_dir_d = rom_dir_q;
      pattern_d = pattern_q;
      level_d   = level_q;
      idx_d     = idx_q;
      replay_d  = replay_q;
      show_d    = show_q;
      busy_d    = busy_q;
      win_d     = win_q;
      lose_d    = lose_q;
      tick_d    = '0;
      last_step = (idx_q == (level_q - 4'd1));

      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               state_d   = S_FETCH;
               rom_dir_d = sel;
               win_d     = 1'b0;
               lose_d    = 1'b0;
               level_d   = 4'd1;
               idx_d     = 4'd0;
               replay_d  = 1'b0;
               busy_d    = 1'b1;
               show_d    = 3'd0;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // Show step 0 straight from the ROM word so it appears with the latch.
            pattern_d = rom_dato;
            show_d    = rom_dato[29:27];
            state_d   = S_SHOW;
         end
         S_SHOW: begin
            if (tick_q == STEP_LAST) begin
               show_d  = 3'd0;
               state_d = S_GAP;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         S_GAP: begin
            if (tick_q == GAP_LAST) begin
               if (replay_q) begin
                  // Pause after a completed round: start the longer replay.
                  replay_d = 1'b0;
                  idx_d    = 4'd0;
                  show_d   = step_at(pattern_q, 4'd0);
                  state_d  = S_SHOW;
               end else if (!last_step) begin
                  idx_d   = idx_q + 4'd1;
                  show_d  = step_at(pattern_q, idx_q + 4'd1);
                  state_d = S_SHOW;
               end else begin
                  idx_d   = 4'd0;
                  state_d = S_INPUT;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         S_INPUT: begin
            // A press takes priority over a timeout expiring in the same cycle.
            if (btn_valid) begin
               if (btn_code != step_at(pattern_q, idx_q)) begin
                  state_d = S_LOSE;
                  lose_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (!last_step) begin
                  idx_d = idx_q + 4'd1;
               end else if (level_q == MAX_LEVEL) begin
                  state_d = S_WIN;
                  win_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  level_d  = level_q + 4'd1;
                  idx_d    = 4'd0;
                  replay_d = 1'b1;
                  state_d  = S_GAP;
               end
            end else if (TO_EN && (tick_q == TO_LAST)) begin
               state_d = S_LOSE;
               lose_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (TO_EN) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rom_dir_q <= 4'd0;
         pattern_q <= 30'd0;
         level_q   <= 4'd0;
         idx_q     <= 4'd0;
         replay_q  <= 1'b0;
         show_q    <= 3'd0;
         busy_q    <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         tick_q    <= '0;
      end else begin
         state_q   <= state_d;
         rom_dir_q <= rom_dir_d;
         pattern_q <= pattern_d;
         level_q   <= level_d;
         idx_q     <= idx_d;
         replay_q  <= replay_d;
         show_q    <= show_d;
         busy_q    <= busy_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         tick_q    <= tick_d;
      end
   end

   assign rom_dir   = rom_dir_q;
   assign show_code = show_q;
   assign level     = level_q;
   assign busy      = busy_q;
   assign win       = win_q;
   assign lose      = lose_q;

endmodule
